wb_bus_top: RTL and testbench

//   Shared-bus Wishbone interconnect: 2 masters, 2 slaves. It arbitrates between the masters,

---
 rtl/wb_bus_top.sv | 174 +++++++++++++++++
 tb/tb_wb_bus_top.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_top.sv
// Shared-bus Wishbone interconnect, 2 masters / 2 slaves, round-robin grant, 0-cycle routing.
// Ports: clk_i, rst_i (async, active low), mN_* master side, sN_* slave side, grant_o. Macro: WB_DEFAULT_ERR_EN.
module wb_bus_top #(
  parameter int DW = 32,
  parameter int AW = 8,
  parameter int SELW = 4,
  parameter int S0_ADDR_W = 8,
  parameter logic [S0_ADDR_W-1:0] S0_ADDR = 8'h40,
  parameter int S1_ADDR_W = 8,
  parameter logic [S1_ADDR_W-1:0] S1_ADDR = 8'h90
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [DW-1:0]   m0_dat_i,
  output logic [DW-1:0]   m0_dat_o,
  input  logic [AW-1:0]   m0_adr_i,
  input  logic [SELW-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic            m0_cab_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,
  input  logic [DW-1:0]   m1_dat_i,
  output logic [DW-1:0]   m1_dat_o,
  input  logic [AW-1:0]   m1_adr_i,
  input  logic [SELW-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic            m1_cab_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,
  output logic [DW-1:0]   s0_dat_o,
  input  logic [DW-1:0]   s0_dat_i,
  output logic [AW-1:0]   s0_adr_o,
  output logic [SELW-1:0] s0_sel_o,
  output logic            s0_we_o,
  output logic            s0_cyc_o,
  output logic            s0_stb_o,
  output logic            s0_cab_o,
  output logic [2:0]      s0_cti_o,
  output logic [1:0]      s0_bte_o,
  input  logic            s0_ack_i,
  input  logic            s0_err_i,
  input  logic            s0_rty_i,
  output logic [DW-1:0]   s1_dat_o,
  input  logic [DW-1:0]   s1_dat_i,
  output logic [AW-1:0]   s1_adr_o,
  output logic [SELW-1:0] s1_sel_o,
  output logic            s1_we_o,
  output logic            s1_cyc_o,
  output logic            s1_stb_o,
  output logic            s1_cab_o,
  output logic [2:0]      s1_cti_o,
  output logic [1:0]      s1_bte_o,
  input  logic            s1_ack_i,
  input  logic            s1_err_i,
  input  logic            s1_rty_i,
  output logic            grant_o
);

  logic grant;
  logic own_cyc, oth_cyc;

  assign own_cyc = grant ? m1_cyc_i : m0_cyc_i;
  assign oth_cyc = grant ? m0_cyc_i : m1_cyc_i;

  // Owner keeps the bus until it drops cyc; no preemption.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i)
      grant <= 1'b0;
    else if (!own_cyc && oth_cyc)
      grant <= ~grant;
  end

  assign grant_o = grant;

  logic [AW-1:0]   g_adr;
  logic [DW-1:0]   g_dat;
  logic [SELW-1:0] g_sel;
  logic [2:0]      g_cti;
  logic [1:0]      g_bte;
  logic            g_we, g_cab, g_stb;

  assign g_adr = grant ? m1_adr_i : m0_adr_i;
  assign g_dat = grant ? m1_dat_i : m0_dat_i;
  assign g_sel = grant ? m1_sel_i : m0_sel_i;
  assign g_cti = grant ? m1_cti_i : m0_cti_i;
  assign g_bte = grant ? m1_bte_i : m0_bte_i;
  assign g_we  = grant ? m1_we_i  : m0_we_i;
  assign g_cab = grant ? m1_cab_i : m0_cab_i;
  assign g_stb = grant ? m1_stb_i : m0_stb_i;

  logic hit0, hit1, sel0, sel1;
  logic live, strobe;

  assign hit0 = g_adr[AW-1 -: S0_ADDR_W] == S0_ADDR;
  assign hit1 = g_adr[AW-1 -: S1_ADDR_W] == S1_ADDR;
  assign sel0 = hit0;
  assign sel1 = hit1 & ~hit0;

  // Reset gates the live cycle so outputs drop without waiting for a clock.
  assign live   = rst_i & own_cyc;
  assign strobe = live & g_stb;

  assign s0_adr_o = g_adr;
  assign s0_dat_o = g_dat;
  assign s0_sel_o = g_sel;
  assign s0_we_o  = g_we;
  assign s0_cab_o = g_cab;
  assign s0_cti_o = g_cti;
  assign s0_bte_o = g_bte;
  assign s1_adr_o = g_adr;
  assign s1_dat_o = g_dat;
  assign s1_sel_o = g_sel;
  assign s1_we_o  = g_we;
  assign s1_cab_o = g_cab;
  assign s1_cti_o = g_cti;
  assign s1_bte_o = g_bte;

  assign s0_cyc_o = live & sel0;
  assign s0_stb_o = strobe & sel0;
  assign s1_cyc_o = live & sel1;
  assign s1_stb_o = strobe & sel1;

  logic [DW-1:0] rd;
  logic ack, err, rty;

  always_comb begin
    rd  = '0;
    ack = 1'b0;
    err = 1'b0;
    rty = 1'b0;
    unique case (1'b1)
      sel0: begin
        rd  = s0_dat_i;
        ack = s0_ack_i;
        err = s0_err_i;
        rty = s0_rty_i;
      end
      sel1: begin
        rd  = s1_dat_i;
        ack = s1_ack_i;
        err = s1_err_i;
        rty = s1_rty_i;
      end
      default: begin
`ifdef WB_DEFAULT_ERR_EN
        err = 1'b1;
`else
        err = 1'b0;
`endif
      end
    endcase
  end

  assign m0_dat_o = rd;
  assign m1_dat_o = rd;

  assign m0_ack_o = strobe & ack & ~grant;
  assign m0_err_o = strobe & err & ~grant;
  assign m0_rty_o = strobe & rty & ~grant;
  assign m1_ack_o = strobe & ack & grant;
  assign m1_err_o = strobe & err & grant;
  assign m1_rty_o = strobe & rty & grant;

endmodule

// File: tb/tb_wb_bus_top.sv
// Self-checking bench for wb_bus_top: decode/routing vector table plus
// arbitration and reset sequences.
module tb_wb_bus_top;

  logic clk = 0;
  logic rst = 0;

  logic [31:0] m0_dat_i, m0_dat_o, m1_dat_i, m1_dat_o;
  logic [7:0]  m0_adr, m1_adr;
  logic [3:0]  m0_sel, m1_sel;
  logic        m0_we, m0_cyc, m0_stb, m0_cab;
  logic        m1_we, m1_cyc, m1_stb, m1_cab;
  logic [2:0]  m0_cti, m1_cti;
  logic [1:0]  m0_bte, m1_bte;
  logic        m0_ack, m0_err, m0_rty, m1_ack, m1_err, m1_rty;
  logic [31:0] s0_dat_o, s0_dat_i, s1_dat_o, s1_dat_i;
  logic [7:0]  s0_adr, s1_adr;
  logic [3:0]  s0_sel, s1_sel;
  logic        s0_we, s0_cyc, s0_stb, s0_cab;
  logic        s1_we, s1_cyc, s1_stb, s1_cab;
  logic [2:0]  s0_cti, s1_cti;
  logic [1:0]  s0_bte, s1_bte;
  logic        s0_ack, s0_err, s0_rty, s1_ack, s1_err, s1_rty;
  logic        grant;

  int checks = 0;
  int errors = 0;

`ifdef WB_DEFAULT_ERR_EN
  localparam logic UNMAP_ERR = 1'b1;
`else
  localparam logic UNMAP_ERR = 1'b0;
`endif

  always #5 clk = ~clk;

  wb_bus_top dut (
    .clk_i(clk), .rst_i(rst),
    .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_adr_i(m0_adr),
    .m0_sel_i(m0_sel), .m0_we_i(m0_we), .m0_cyc_i(m0_cyc),
    .m0_stb_i(m0_stb), .m0_cab_i(m0_cab), .m0_cti_i(m0_cti),
    .m0_bte_i(m0_bte), .m0_ack_o(m0_ack), .m0_err_o(m0_err),
    .m0_rty_o(m0_rty),
    .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_adr_i(m1_adr),
    .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_cyc_i(m1_cyc),
    .m1_stb_i(m1_stb), .m1_cab_i(m1_cab), .m1_cti_i(m1_cti),
    .m1_bte_i(m1_bte), .m1_ack_o(m1_ack), .m1_err_o(m1_err),
    .m1_rty_o(m1_rty),
    .s0_dat_o(s0_dat_o), .s0_dat_i(s0_dat_i), .s0_adr_o(s0_adr),
    .s0_sel_o(s0_sel), .s0_we_o(s0_we), .s0_cyc_o(s0_cyc),
    .s0_stb_o(s0_stb), .s0_cab_o(s0_cab), .s0_cti_o(s0_cti),
    .s0_bte_o(s0_bte), .s0_ack_i(s0_ack), .s0_err_i(s0_err),
    .s0_rty_i(s0_rty),
    .s1_dat_o(s1_dat_o), .s1_dat_i(s1_dat_i), .s1_adr_o(s1_adr),
    .s1_sel_o(s1_sel), .s1_we_o(s1_we), .s1_cyc_o(s1_cyc),
    .s1_stb_o(s1_stb), .s1_cab_o(s1_cab), .s1_cti_o(s1_cti),
    .s1_bte_o(s1_bte), .s1_ack_i(s1_ack), .s1_err_i(s1_err),
    .s1_rty_i(s1_rty),
    .grant_o(grant)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  adr;
    logic        stb;
    logic        we;
    logic [31:0] wdat;
    logic        s0a;
    logic        s1a;
    logic        s1e;
    logic        e_s0stb;
    logic        e_s1stb;
    logic        e_ack;
    logic        e_err;
    logic [31:0] e_dat;
  } vec_t;

  vec_t vt [7];

  initial begin
    m0_dat_i = 0; m1_dat_i = 0; m0_sel = 4'hf; m1_sel = 4'h3;
    m0_adr = 8'h40; m1_adr = 8'h90;
    m0_we = 0; m1_we = 0; m0_cab = 0; m1_cab = 0;
    m0_cti = 0; m1_cti = 0; m0_bte = 0; m1_bte = 0;
    m0_cyc = 1; m0_stb = 1; m1_cyc = 1; m1_stb = 1;
    s0_dat_i = 32'h11; s1_dat_i = 32'h35;
    s0_ack = 1; s0_err = 0; s0_rty = 0;
    s1_ack = 0; s1_err = 0; s1_rty = 0;

    vt[0] = '{8'h40, 1, 1, 32'h20, 1, 0, 0, 1, 0, 1, 0, 32'h11};
    vt[1] = '{8'h40, 1, 0, 32'h07, 0, 0, 0, 1, 0, 0, 0, 32'h11};
    vt[2] = '{8'h40, 0, 1, 32'h08, 1, 0, 0, 0, 0, 0, 0, 32'h11};
    vt[3] = '{8'h90, 1, 0, 32'h09, 1, 1, 0, 0, 1, 1, 0, 32'h35};
    vt[4] = '{8'h90, 1, 0, 32'h0a, 0, 0, 1, 0, 1, 0, 1, 32'h35};
    vt[5] = '{8'h55, 1, 0, 32'h0b, 1, 1, 0, 0, 0, 0, UNMAP_ERR, 0};
    vt[6] = '{8'h41, 1, 1, 32'h0c, 1, 1, 0, 0, 0, 0, UNMAP_ERR, 0};

    // Reset held with both masters requesting
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_s0_cyc", s0_cyc, 0);
    chk("rst_s0_stb", s0_stb, 0);
    chk("rst_s1_cyc", s1_cyc, 0);
    chk("rst_m0_ack", m0_ack, 0);
    chk("rst_m1_ack", m1_ack, 0);

    // Both request after reset: m0 first
    @(negedge clk);
    rst = 1;
    #1;
    chk("arb_m0_ack", m0_ack, 1);
    chk("arb_m1_ack", m1_ack, 0);
    chk("arb_s1_stb", s1_stb, 0);
    @(posedge clk); #1;
    chk("arb_hold", grant, 0);
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0; s1_ack = 1;
    #1;
    chk("arb_pre_sw", grant, 0);
    @(posedge clk); #1;
    chk("arb_sw1", grant, 1);
    chk("arb_s1_stb1", s1_stb, 1);
    chk("arb_m1_ack1", m1_ack, 1);
    chk("arb_m1_dat", m1_dat_o, 32'h35);
    chk("arb_m0_ack1", m0_ack, 0);
    @(negedge clk);
    m0_cyc = 1; m0_stb = 1;
    @(posedge clk); #1;
    chk("arb_nopreempt", grant, 1);
    @(negedge clk);
    m1_cyc = 0; m1_stb = 0; s1_ack = 0;
    @(posedge clk); #1;
    chk("arb_back_m0", grant, 0);

    // Routing table, m0 owns, m1 idle
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      m0_adr = vt[i].adr; m0_stb = vt[i].stb;
      m0_we = vt[i].we; m0_dat_i = vt[i].wdat;
      s0_ack = vt[i].s0a; s1_ack = vt[i].s1a; s1_err = vt[i].s1e;
      #1;
      chk($sformatf("v%0d_s0stb", i), s0_stb, vt[i].e_s0stb);
      chk($sformatf("v%0d_s1stb", i), s1_stb, vt[i].e_s1stb);
      chk($sformatf("v%0d_ack", i), m0_ack, vt[i].e_ack);
      chk($sformatf("v%0d_err", i), m0_err, vt[i].e_err);
      chk($sformatf("v%0d_dat", i), m0_dat_o, vt[i].e_dat);
      chk($sformatf("v%0d_m1dat", i), m1_dat_o, vt[i].e_dat);
      chk($sformatf("v%0d_wdat", i), s0_dat_o, vt[i].wdat);
      chk($sformatf("v%0d_we", i), s1_we, vt[i].we);
      chk($sformatf("v%0d_adr", i), s1_adr, vt[i].adr);
      chk($sformatf("v%0d_m1ack", i), m1_ack | m1_err, 0);
      chk($sformatf("v%0d_grant", i), grant, 0);
    end

    // m1 read, m0 idle, then reset mid-access
    @(negedge clk);
    m0_cyc = 0; m0_stb = 0; s1_err = 0; s1_ack = 1;
    m1_cyc = 1; m1_stb = 1; m1_adr = 8'h90;
    #1;
    chk("m1_pre_grant", grant, 0);
    @(posedge clk); #1;
    chk("m1_grant", grant, 1);
    chk("m1_ack", m1_ack, 1);
    chk("m1_s1cyc", s1_cyc, 1);
    #2;
    rst = 0;
    #1;
    chk("mid_rst_s1cyc", s1_cyc, 0);
    chk("mid_rst_s1stb", s1_stb, 0);
    chk("mid_rst_m1ack", m1_ack, 0);
    chk("mid_rst_grant", grant, 0);
    @(negedge clk);
    rst = 1;
    @(posedge clk); #1;
    chk("post_rst_regrant", grant, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
